// File: rtl/vga_pkg.sv
// Shared VGA timing presets, colour width and colour-bar palette.
// Used by vga_timing_gen and vga_axis_counter.
package vga_pkg;

    localparam int RGB_W = 12;

    typedef logic [RGB_W-1:0] rgb_t;

    // 800x600@72 with a 50 MHz pixel clock
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 56;
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BP     = 64;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 37;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_HS_POL   = 1'b1;
    localparam bit SVGA_VS_POL   = 1'b1;
    localparam int SVGA_CE_DIV   = 1;

    // 640x480@60 with a 25 MHz pixel enable
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam bit VGA_HS_POL    = 1'b0;
    localparam bit VGA_VS_POL    = 1'b0;
    localparam int VGA_CE_DIV    = 2;

    localparam rgb_t BAR_WHITE   = 12'hFFF;
    localparam rgb_t BAR_YELLOW  = 12'hFF0;
    localparam rgb_t BAR_CYAN    = 12'h0FF;
    localparam rgb_t BAR_GREEN   = 12'h0F0;
    localparam rgb_t BAR_MAGENTA = 12'hF0F;
    localparam rgb_t BAR_RED     = 12'hF00;
    localparam rgb_t BAR_BLUE    = 12'h00F;
    localparam rgb_t BAR_BLACK   = 12'h000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c = BAR_BLACK;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts FP, SYNC, BP, ACTIVE segments in that order
// and flags the sync and active segments.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int FP     = 56,
    parameter int SYNC   = 120,
    parameter int BP     = 64,
    parameter int ACTIVE = 800,
    localparam int TOTAL = FP + SYNC + BP + ACTIVE,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_seg,
    output logic         active,
    output logic [W-1:0] active_idx
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(FP);
    localparam logic [W-1:0] SYNC_HI = W'(FP + SYNC);
    localparam logic [W-1:0] ACT_LO  = W'(FP + SYNC + BP);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (advance) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count      = cnt_q;
    assign wrap       = (cnt_q == LAST);
    assign sync_seg   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
    assign active     = (cnt_q >= ACT_LO);
    assign active_idx = cnt_q - ACT_LO;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: counters -> stage A (syncs, request) -> stage B (pins).
// Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar input.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = SVGA_HS_POL,
    parameter bit VS_POL   = SVGA_VS_POL,
    parameter int CE_DIV   = SVGA_CE_DIV
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic             pixel_req,
    output logic [10:0]      pixel_x,
    output logic [9:0]       pixel_y,
    input  logic [RGB_W-1:0] pixel_rgb,
    output logic             frame_start,
    output logic             in_vblank,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic ce;

    generate
        if (CE_DIV <= 1) begin : g_ce_one
            assign ce = 1'b1;
        end else begin : g_ce_div
            localparam int DW = $clog2(CE_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
            logic [DW-1:0] div_q, div_d;

            always_comb begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
            end

            always_ff @(posedge MAX10_CLK1_50) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign ce = (div_q == DIV_LAST);
        end
    endgenerate

    logic [HW-1:0] h_cnt, h_idx;
    logic [VW-1:0] v_cnt, v_idx;
    logic          h_wrap, h_sync, h_act;
    logic          v_wrap, v_sync, v_act;

    vga_axis_counter #(
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE)
    ) u_h (
        .clk        (MAX10_CLK1_50),
        .reset      (reset),
        .advance    (ce),
        .count      (h_cnt),
        .wrap       (h_wrap),
        .sync_seg   (h_sync),
        .active     (h_act),
        .active_idx (h_idx)
    );

    vga_axis_counter #(
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE)
    ) u_v (
        .clk        (MAX10_CLK1_50),
        .reset      (reset),
        .advance    (ce & h_wrap),
        .count      (v_cnt),
        .wrap       (v_wrap),
        .sync_seg   (v_sync),
        .active     (v_act),
        .active_idx (v_idx)
    );

    // Stage A
    logic        de_d, de_q;
    logic        hs_d, hs_q;
    logic        vs_d, vs_q;
    logic        req_d, req_q;
    logic        fs_d, fs_q;
    logic        vb_d, vb_q;
    logic [10:0] x_d, x_q;
    logic [9:0]  y_d, y_q;
    logic        pstb_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic          tm_d, tm_q;
    rgb_t          bar_d, bar_q;
    logic [HW-1:0] bar_n;

    always_comb begin
        tm_d  = test_mode;
        bar_n = h_idx / HW'(BAR_W);
        bar_d = bar_colour((bar_n > HW'(7)) ? 3'd7 : bar_n[2:0]);
    end
`endif

    always_comb begin
        de_d  = h_act & v_act;
        hs_d  = h_sync ? HS_POL : !HS_POL;
        vs_d  = v_sync ? VS_POL : !VS_POL;
        fs_d  = (h_cnt == '0) && (v_cnt == '0);
        vb_d  = !v_act;
        x_d   = 11'(h_idx);
        y_d   = 10'(v_idx);
`ifdef VGA_TEST_PATTERN_EN
        req_d = de_d & !test_mode;
`else
        req_d = de_d;
`endif
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            de_q  <= 1'b0;
            hs_q  <= !HS_POL;
            vs_q  <= !VS_POL;
            req_q <= 1'b0;
            fs_q  <= 1'b0;
            vb_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
`ifdef VGA_TEST_PATTERN_EN
            tm_q  <= 1'b0;
            bar_q <= '0;
`endif
        end else if (ce) begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            req_q <= req_d;
            fs_q  <= fs_d;
            vb_q  <= vb_d;
            x_q   <= x_d;
            y_q   <= y_d;
`ifdef VGA_TEST_PATTERN_EN
            tm_q  <= tm_d;
            bar_q <= bar_d;
`endif
        end
    end

    // Strobes last only the clock right after the ce edge that set them
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            pstb_q <= 1'b0;
        end else begin
            pstb_q <= ce;
        end
    end

    // Stage B
    rgb_t rgb_d, rgb_q;
    logic hs_b_q, vs_b_q;

    always_comb begin
        rgb_d = '0;
`ifdef VGA_TEST_PATTERN_EN
        if (de_q) begin
            rgb_d = tm_q ? bar_q : pixel_rgb;
        end
`else
        if (de_q) begin
            rgb_d = pixel_rgb;
        end
`endif
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            rgb_q  <= '0;
            hs_b_q <= !HS_POL;
            vs_b_q <= !VS_POL;
        end else if (ce) begin
            rgb_q  <= rgb_d;
            hs_b_q <= hs_q;
            vs_b_q <= vs_q;
        end
    end

    assign pixel_req   = req_q & pstb_q;
    assign frame_start = fs_q & pstb_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign in_vblank   = vb_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_b_q;
    assign VGA_VS      = vs_b_q;

endmodule
